// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, tick divider math and the default frame width.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int FRAME_WIDTH_DEF = 8;

  // Integer truncation is deliberate: the receiver resyncs on every start bit.
  function automatic int calc_div(input int source_clk, input int target_clk, input int oversample);
    return source_clk / (target_clk * oversample);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick divider: one-cycle tick every DIV hwclk cycles; clr holds the phase at zero.
// Latency: tick is combinational from the counter; no backpressure.
module uart_tick_gen #(
  parameter int DIV    = 78,
  parameter int CNTR_W = 16
) (
  input  logic hwclk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam logic [CNTR_W-1:0] LAST = CNTR_W'(DIV - 1);

  logic [CNTR_W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge hwclk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined) with a one-entry valid/ready holding register.
// Latency: rx_valid rises the hwclk cycle after the mid-stop-bit sample; line passes a 2-flop synchronizer.
// Backpressure: a byte completing while the register is full and rx_ready is low is dropped and flagged on overrun.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int SOURCE_CLK  = 12000000,
  parameter int TARGET_CLK  = 9600,
  parameter int OVERSAMPLE  = 16,
  parameter int CNTR_W      = 16,
  parameter int FRAME_WIDTH = FRAME_WIDTH_DEF
) (
  input  logic                   hwclk,
  input  logic                   rst_n,
  input  logic                   ftdi_rx,
  output logic [FRAME_WIDTH-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   parity_err,
  output logic                   rx_busy
);

  localparam int DIV = calc_div(SOURCE_CLK, TARGET_CLK, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(FRAME_WIDTH);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(FRAME_WIDTH - 1);

  rx_state_t              state;
  logic                   rx_m;
  logic                   rx_s;
  logic                   armed;
  logic [TW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [FRAME_WIDTH-1:0] shreg;
  logic                   tick;
  logic                   bit_end;
`ifdef UART_RX_PARITY_EN
  logic                   par_bit;
`endif

  // Holding the divider in clear while idle phase-aligns ticks to the start edge.
  uart_tick_gen #(
    .DIV    (DIV),
    .CNTR_W (CNTR_W)
  ) u_tick_gen (
    .hwclk (hwclk),
    .rst_n (rst_n),
    .clr   (state == IDLE),
    .tick  (tick)
  );

  assign bit_end = tick && (tick_cnt == T_END);
  assign rx_busy = (state != IDLE);

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      armed     <= 1'b0;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_m      <= ftdi_rx;
      rx_s      <= rx_m;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed <= 1'b0;
            state <= START;
          end
        end
        START: if (tick) begin
          if (tick_cnt == T_MID) begin
            tick_cnt <= '0;
            state    <= rx_s ? IDLE : DATA;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        DATA: if (tick) begin
          if (tick_cnt == T_END) begin
            tick_cnt <= '0;
            shreg    <= {rx_s, shreg[FRAME_WIDTH-1:1]};
            bit_cnt  <= bit_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bit_cnt == B_LAST) state <= PARITY;
`else
            if (bit_cnt == B_LAST) state <= STOP;
`endif
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (tick) begin
          if (tick_cnt == T_END) begin
            tick_cnt <= '0;
            par_bit  <= rx_s;
            state    <= STOP;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
`endif
        STOP: if (tick) begin
          if (bit_end) begin
            tick_cnt <= '0;
            state    <= IDLE;
            // A framing error outranks a parity error; either discards the byte.
            if (!rx_s) begin
              frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (^{shreg, par_bit}) begin
              parity_err <= 1'b1;
`endif
            end else if (!rx_valid || rx_ready) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1 with a shortened divider (DIV=5, so 80 hwclk per bit).
module tb_uart_rx_8n1;

  localparam int SRC = 800000;   // 800000/(9600*16) truncates to 5
  localparam int BIT = 80;

  logic       hwclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ftdi_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;
  logic       rx_busy;

  uart_rx_8n1 #(
    .SOURCE_CLK  (SRC),
    .TARGET_CLK  (9600),
    .OVERSAMPLE  (16),
    .CNTR_W      (16),
    .FRAME_WIDTH (8)
  ) dut (
    .hwclk      (hwclk),
    .rst_n      (rst_n),
    .ftdi_rx    (ftdi_rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .rx_busy    (rx_busy)
  );

  always #5 hwclk = ~hwclk;

  int         acc_cnt  = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt  = 0;
  int         perr_cnt = 0;
  logic [7:0] last_acc = 8'h00;

  always @(negedge hwclk) begin
    if (rx_valid && rx_ready) begin
      acc_cnt  <= acc_cnt + 1;
      last_acc <= rx_data;
    end
    if (frame_err)  ferr_cnt <= ferr_cnt + 1;
    if (overrun)    ovr_cnt  <= ovr_cnt + 1;
    if (parity_err) perr_cnt <= perr_cnt + 1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge hwclk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    ftdi_rx = 1'b0;
    step(BIT);
    for (int i = 0; i < 8; i++) begin
      ftdi_rx = d[i];
      step(BIT);
    end
`ifdef UART_RX_PARITY_EN
    ftdi_rx = ^d;
    step(BIT);
`endif
    ftdi_rx = stop;
    step(BIT);
    ftdi_rx = 1'b1;
    step(BIT);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_par_frame(input logic [7:0] d, input logic par);
    ftdi_rx = 1'b0;
    step(BIT);
    for (int i = 0; i < 8; i++) begin
      ftdi_rx = d[i];
      step(BIT);
    end
    ftdi_rx = par;
    step(BIT);
    ftdi_rx = 1'b1;
    step(2 * BIT);
  endtask
`endif

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_acc;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t vt[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, f0, o0, p0;

    vt[0] = '{8'h48, 1'b1, 1, 8'h48, 0};
    vt[1] = '{8'h55, 1'b0, 0, 8'h00, 1};
    vt[2] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
    vt[3] = '{8'h00, 1'b1, 1, 8'h00, 0};
    vt[4] = '{8'hFF, 1'b1, 1, 8'hFF, 0};

    step(4);
    chk("reset rx_data",    32'(rx_data),    32'h0);
    chk("reset rx_valid",   32'(rx_valid),   32'h0);
    chk("reset frame_err",  32'(frame_err),  32'h0);
    chk("reset overrun",    32'(overrun),    32'h0);
    chk("reset parity_err", 32'(parity_err), 32'h0);
    chk("reset rx_busy",    32'(rx_busy),    32'h0);
    rst_n = 1'b1;
    step(2 * BIT);

    for (int v = 0; v < 5; v++) begin
      a0 = acc_cnt; f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt;
      send_frame(vt[v].data, vt[v].stop);
      chk($sformatf("vec%0d accepts", v), 32'(acc_cnt - a0), 32'(vt[v].exp_acc));
      if (vt[v].exp_acc != 0)
        chk($sformatf("vec%0d data", v), 32'(last_acc), 32'(vt[v].exp_data));
      chk($sformatf("vec%0d frame_err", v), 32'(ferr_cnt - f0), 32'(vt[v].exp_ferr));
      chk($sformatf("vec%0d overrun", v), 32'(ovr_cnt - o0), 32'h0);
      chk($sformatf("vec%0d parity_err", v), 32'(perr_cnt - p0), 32'h0);
      chk($sformatf("vec%0d rx_busy", v), 32'(rx_busy), 32'h0);
      chk($sformatf("vec%0d rx_valid", v), 32'(rx_valid), 32'h0);
    end

    // Short low glitch must not start a frame.
    a0 = acc_cnt; f0 = ferr_cnt;
    ftdi_rx = 1'b0;
    step(10);
    chk("glitch busy during", 32'(rx_busy), 32'h1);
    step(5);
    ftdi_rx = 1'b1;
    step(BIT);
    chk("glitch busy after", 32'(rx_busy), 32'h0);
    chk("glitch accepts",    32'(acc_cnt - a0), 32'h0);
    chk("glitch frame_err",  32'(ferr_cnt - f0), 32'h0);

    // Overrun: consumer stalled across two bytes.
    rx_ready = 1'b0;
    a0 = acc_cnt; o0 = ovr_cnt;
    send_frame(8'h01, 1'b1);
    chk("ovr first valid", 32'(rx_valid), 32'h1);
    chk("ovr first data",  32'(rx_data),  32'h01);
    send_frame(8'h02, 1'b1);
    chk("ovr pulses",      32'(ovr_cnt - o0), 32'h1);
    chk("ovr data kept",   32'(rx_data),  32'h01);
    chk("ovr still valid", 32'(rx_valid), 32'h1);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    step(1);
    chk("ovr drain valid", 32'(rx_valid), 32'h0);
    chk("ovr drain data",  32'(rx_data),  32'h01);
    chk("ovr drain accept", 32'(acc_cnt - a0), 32'h1);
    chk("ovr drain byte",  32'(last_acc), 32'h01);
    rx_ready = 1'b1;

    // Reset in the middle of 0x3C's data bits, then a clean 0xC3.
    a0 = acc_cnt;
    ftdi_rx = 1'b0;
    step(BIT);
    ftdi_rx = 1'b0;
    step(BIT);
    ftdi_rx = 1'b0;
    step(BIT / 2);
    chk("rst busy before", 32'(rx_busy), 32'h1);
    rst_n = 1'b0;
    step(1);
    chk("rst busy after",  32'(rx_busy),  32'h0);
    chk("rst valid after", 32'(rx_valid), 32'h0);
    rst_n = 1'b1;
    ftdi_rx = 1'b1;
    step(2 * BIT);
    send_frame(8'hC3, 1'b1);
    chk("rst accepts", 32'(acc_cnt - a0), 32'h1);
    chk("rst byte",    32'(last_acc), 32'hC3);

`ifdef UART_RX_PARITY_EN
    a0 = acc_cnt; p0 = perr_cnt;
    send_par_frame(8'h07, 1'b0);
    chk("par bad pulses",  32'(perr_cnt - p0), 32'h1);
    chk("par bad accepts", 32'(acc_cnt - a0), 32'h0);
    send_par_frame(8'h07, 1'b1);
    chk("par good pulses",  32'(perr_cnt - p0), 32'h1);
    chk("par good accepts", 32'(acc_cnt - a0), 32'h1);
    chk("par good byte",    32'(last_acc), 32'h07);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_8n1.md
Name: uart_rx_8n1

Overview:
- 8N1 UART receiver that consumes the host-to-FPGA serial line, which is the return path of the existing shift-register transmitter.
- Oversamples the line at 16x baud, derived from hwclk by an internal tick divider.
- Delivers each received byte on a one-entry valid/ready holding register.
- Flags framing errors and overruns, which will drive LEDs and an echo/loopback test top.

Parameters:
- SOURCE_CLK, 12000000: hwclk frequency in Hz.
- TARGET_CLK, 9600: baud rate (4800, 9600, 115200 supported).
- OVERSAMPLE, 16: ticks per bit; must be even and >= 8.
- CNTR_W, 16: tick divider counter width.
- FRAME_WIDTH, 8: data bits per frame.

Ports:
- hwclk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- ftdi_rx  input  1  asynchronous serial line, idle high.
- rx_data  output  FRAME_WIDTH  received byte, LSB = first bit on the wire.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: completed byte dropped because the holding register was full.
- parity_err  output  1  one-cycle pulse (see Optional Feature); tied 0 when the feature is compiled out.
- rx_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, parity_err=0, rx_busy=0. FSM=IDLE, synchronizer flops preset to 1, armed=0.
- Synchronizer: 2-flop synchronizer on ftdi_rx produces rx_s. The line is used only after synchronization, giving 2 hwclk of latency.
- Tick generator:
  - DIV = SOURCE_CLK/(TARGET_CLK*OVERSAMPLE), integer truncation (12 MHz at 9600 baud gives 78).
  - Counter runs 0..DIV-1 and emits a one-cycle tick at DIV-1.
  - Counter is reset to 0 on the start-bit edge, so ticks are phase-aligned to each frame.
- armed flag: set when rx_s==1 in IDLE; cleared on entering START. A start bit is detected only when armed, so a line held low (break, or after a framing error) does not retrigger.
- FSM states:
  - IDLE: armed && rx_s==0 → START; tick count and bit count cleared.
  - START: on tick OVERSAMPLE/2 (mid start bit), sample rx_s. If 1, it was a glitch → IDLE with no outputs. If 0 → DATA with tick count cleared.
  - DATA: every OVERSAMPLE ticks, sample rx_s into the shift register (right shift, MSB in). After FRAME_WIDTH samples → STOP (or → PARITY when the feature is enabled).
  - STOP: after OVERSAMPLE ticks, sample rx_s.
    - If 1: byte completes and FSM → IDLE.
    - If 0: frame_err pulses, byte is discarded, FSM → IDLE (armed=0).
- Completion latency: rx_valid rises on the hwclk cycle after the mid-stop-bit sample.
- Holding register rules:
  - Byte completes and rx_valid=0: load rx_data, set rx_valid.
  - Byte completes, rx_valid=1, rx_ready=1 in the same cycle: load the new byte, rx_valid stays 1, no overrun.
  - Byte completes, rx_valid=1, rx_ready=0: overrun pulses, old rx_data is kept, new byte is dropped.
  - rx_valid && rx_ready with no completion: rx_valid clears next cycle; rx_data holds its last value.
- Error pulses: frame_err, overrun and parity_err last exactly one hwclk cycle.
- Reset mid-frame: rst_n low on any cycle aborts the frame. Outputs return to reset values on the next edge; no partial byte is delivered.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP that samples one even-parity bit after OVERSAMPLE ticks. Frame format becomes 8E1.
  - On mismatch, parity_err pulses at the stop-bit sample and the byte is discarded. A framing error takes priority if both occur.
- Undefined: no PARITY state, format is 8N1, parity_err is constant 0.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - function computing DIV from SOURCE_CLK/TARGET_CLK/OVERSAMPLE;
  - FRAME_WIDTH default constant, shared with the transmitter.
- One sub-module, uart_tick_gen: tick divider with a synchronous clear input, reusable by the transmitter.

Test Plan:
- Send 0x48 at 9600 baud (104.17 µs/bit) with rx_ready=1 → one rx_valid pulse with rx_data=0x48, no error pulses, rx_busy low afterwards.
- Low glitch on ftdi_rx of 3 ticks (~234 hwclk) → no rx_valid, FSM back in IDLE, no frame_err.
- Send 0x55 with stop bit forced 0, then hold the line high for 1 bit, then send 0xA5 → frame_err pulses once, then rx_data=0xA5 valid.
- rx_ready=0; send 0x01 then 0x02 → overrun pulses once at the second stop, rx_data stays 0x01. Then assert rx_ready for 1 cycle → rx_valid drops.
- Assert rst_n=0 for 1 cycle mid-DATA of 0x3C, then send 0xC3 → only 0xC3 delivered.
- With UART_RX_PARITY_EN defined: send 0x07 with parity bit 0 (wrong; even parity requires 1) → parity_err pulse, no rx_valid. Resend with parity 1 → rx_data=0x07.
